ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_capture.sv | 141 ++++++++++++++
 tb/tb_ov7670_capture.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: pairs camera bytes into RGB565 pixels with linear
// frame addresses and flags lines or frames whose geometry is wrong.
module ov7670_capture #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240,
  parameter int AW    = 17
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_EN,
  input  logic          I_PCLK,
  input  logic          I_VSYNC,
  input  logic          I_HREF,
  input  logic [7:0]    I_DATA,
  output logic          O_PIX_VALID,
  output logic [15:0]   O_PIX_DATA,
  output logic [AW-1:0] O_PIX_ADDR,
  output logic          O_FRAME_DONE,
  output logic          O_LINE_ERR,
  output logic          O_FRAME_ERR,
  output logic          O_BUSY
);

  localparam int XW = $clog2(H_PIX + 2);
  localparam int YW = $clog2(V_PIX + 1);
  localparam logic [XW-1:0] X_END = XW'(H_PIX);
  localparam logic [XW-1:0] X_SAT = XW'(H_PIX + 1);
  localparam logic [YW-1:0] Y_END = YW'(V_PIX);

  typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE} state_t;

  state_t        r_state;
  logic          r_pclk_d;
  logic          r_href_d;
  logic          r_phase;
  logic          r_armed;
  logic [7:0]    r_hi;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;

  logic          w_tick;
  logic          w_line_end;
  logic          w_pix_ok;
  logic [YW-1:0] w_y_next;

  assign w_tick     = I_PCLK & ~r_pclk_d;
  assign w_line_end = w_tick & ~I_HREF & r_href_d;
  assign w_pix_ok   = (r_x < X_END) && (r_y < Y_END);
  // Line count as it will be after a line end landing in this same cycle.
  assign w_y_next   = (w_line_end && (r_y != Y_END)) ? r_y + YW'(1) : r_y;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state      <= S_IDLE;
      r_pclk_d     <= 1'b0;
      r_href_d     <= 1'b0;
      r_phase      <= 1'b0;
      r_armed      <= 1'b0;
      r_hi         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      O_PIX_VALID  <= 1'b0;
      O_PIX_DATA   <= '0;
      O_PIX_ADDR   <= '0;
      O_FRAME_DONE <= 1'b0;
      O_LINE_ERR   <= 1'b0;
      O_FRAME_ERR  <= 1'b0;
      O_BUSY       <= 1'b0;
    end else begin
      r_pclk_d     <= I_PCLK;
      O_PIX_VALID  <= 1'b0;
      O_FRAME_DONE <= 1'b0;
      O_LINE_ERR   <= 1'b0;
      O_FRAME_ERR  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (I_VSYNC) begin
            r_state <= S_VBLANK;
            r_armed <= 1'b1;
          end
        end
        // A frame starts only on a VSYNC fall seen with I_EN high; a fall with
        // I_EN low disarms until VSYNC is high again.
        S_VBLANK: begin
          if (I_VSYNC) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            if (I_EN) begin
              r_state  <= S_ACTIVE;
              O_BUSY   <= 1'b1;
              r_x      <= '0;
              r_y      <= '0;
              r_addr   <= '0;
              r_phase  <= 1'b0;
              r_href_d <= 1'b0;
            end
          end
        end
        S_ACTIVE: begin
          if (w_tick) begin
            r_href_d <= I_HREF;
            if (I_HREF) begin
              if (!r_phase) begin
                r_hi    <= I_DATA;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (w_pix_ok) begin
                  O_PIX_VALID <= 1'b1;
                  O_PIX_DATA  <= {r_hi, I_DATA};
                  O_PIX_ADDR  <= r_addr;
                  r_addr      <= r_addr + AW'(1);
                end
                // x keeps counting past H_PIX (saturating) so over-long lines
                // are still reported at line end.
                if (r_x != X_SAT) r_x <= r_x + XW'(1);
              end
            end else if (r_href_d) begin
              O_LINE_ERR <= (r_x != X_END) || r_phase;
              r_x        <= '0;
              r_phase    <= 1'b0;
              r_y        <= w_y_next;
            end
          end
          if (I_VSYNC) begin
            r_state      <= S_VBLANK;
            r_armed      <= 1'b1;
            O_BUSY       <= 1'b0;
            O_FRAME_DONE <= 1'b1;
            O_FRAME_ERR  <= (w_y_next != Y_END);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: drives framed byte streams and scoreboards pixels,
// line/frame error strobes and reset behaviour on a 4x3 frame.
module tb_ov7670_capture;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int AWP = 4;

  logic           I_CLK;
  logic           I_RST_N;
  logic           I_EN;
  logic           I_PCLK;
  logic           I_VSYNC;
  logic           I_HREF;
  logic [7:0]     I_DATA;
  logic           O_PIX_VALID;
  logic [15:0]    O_PIX_DATA;
  logic [AWP-1:0] O_PIX_ADDR;
  logic           O_FRAME_DONE;
  logic           O_LINE_ERR;
  logic           O_FRAME_ERR;
  logic           O_BUSY;

  ov7670_capture #(.H_PIX(H), .V_PIX(V), .AW(AWP)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_EN(I_EN), .I_PCLK(I_PCLK),
    .I_VSYNC(I_VSYNC), .I_HREF(I_HREF), .I_DATA(I_DATA),
    .O_PIX_VALID(O_PIX_VALID), .O_PIX_DATA(O_PIX_DATA), .O_PIX_ADDR(O_PIX_ADDR),
    .O_FRAME_DONE(O_FRAME_DONE), .O_LINE_ERR(O_LINE_ERR),
    .O_FRAME_ERR(O_FRAME_ERR), .O_BUSY(O_BUSY)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_pix, n_lerr, n_fdone, n_ferr, n_coinc;
  bit m_armed = 1'b0;
  logic [15:0] qd[$];
  int          qa[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every strobe is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge I_CLK);
      if (I_RST_N) begin
        if (O_PIX_VALID) begin
          n_pix++;
          if (qd.size() == 0) begin
            chk("pix_unexpected", {31'd0, O_PIX_VALID}, 32'd0);
          end else begin
            chk("pix_data", {16'd0, O_PIX_DATA}, {16'd0, qd.pop_front()});
            chk("pix_addr", {28'd0, O_PIX_ADDR}, qa.pop_front());
          end
        end
        if (O_LINE_ERR) n_lerr++;
        if (O_FRAME_DONE) n_fdone++;
        if (O_FRAME_ERR) n_ferr++;
        if (O_FRAME_DONE && O_FRAME_ERR) n_coinc++;
      end
    end
  end

  // One camera byte: PCLK low then high, each for 3 system clocks.
  task automatic pbyte(input logic [7:0] d, input logic h);
    I_PCLK = 1'b0;
    I_DATA = d;
    I_HREF = h;
    repeat (3) @(negedge I_CLK);
    I_PCLK = 1'b1;
    repeat (3) @(negedge I_CLK);
  endtask

  task automatic do_reset(input int last_addr);
    chk("busy_before_rst", {31'd0, O_BUSY}, 32'd1);
    chk("addr_hold", {28'd0, O_PIX_ADDR}, last_addr);
    I_RST_N = 1'b0;
    #1;
    chk("rst_async_data", {16'd0, O_PIX_DATA}, 32'd0);
    chk("rst_async_all", {15'd0, O_PIX_VALID, O_PIX_ADDR, O_FRAME_DONE, O_LINE_ERR,
                          O_FRAME_ERR, O_BUSY, 8'd0}, 32'd0);
    repeat (2) @(negedge I_CLK);
    I_RST_N = 1'b1;
    m_armed = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int nlines, input int long_line,
                           input bit en_start, input bit en_mid, input int rst_after);
    bit cap;
    int exp_pix, exp_lerr, addr, nb;
    n_pix = 0; n_lerr = 0; n_fdone = 0; n_ferr = 0; n_coinc = 0;
    exp_pix = 0; exp_lerr = 0; addr = 0;
    cap = m_armed && en_start;
    I_EN = en_start;
    I_VSYNC = 1'b0;
    pbyte(8'h00, 1'b0);
    pbyte(8'h00, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      nb = (l == long_line) ? 2 * H + 2 : 2 * H;
      for (int b = 0; b < nb; b++) begin
        if (b[0] && cap && (b / 2) < H && l < V) begin
          qd.push_back({8'(b - 1), 8'(b)});
          qa.push_back(addr);
          addr++;
          exp_pix++;
        end
        pbyte(8'(b), 1'b1);
        if (b[0] && cap && rst_after > 0 && exp_pix == rst_after) begin
          do_reset(rst_after - 1);
          cap = 1'b0;
        end
      end
      if (cap && nb != 2 * H) exp_lerr++;
      if (l == 0) I_EN = en_mid;
      if (l != nlines - 1) begin
        pbyte(8'h00, 1'b0);
        pbyte(8'h00, 1'b0);
      end
    end
    // Last line end and VSYNC rise land on the same tick.
    I_PCLK = 1'b0;
    I_HREF = 1'b0;
    I_DATA = 8'h00;
    repeat (3) @(negedge I_CLK);
    I_PCLK = 1'b1;
    I_VSYNC = 1'b1;
    repeat (3) @(negedge I_CLK);
    repeat (3) pbyte(8'h00, 1'b0);
    m_armed = 1'b1;
    chk({nm, "_strobes"}, n_pix, exp_pix);
    chk({nm, "_line_err"}, n_lerr, exp_lerr);
    chk({nm, "_frame_done"}, n_fdone, {31'd0, cap});
    chk({nm, "_frame_err"}, n_ferr, (cap && nlines != V) ? 1 : 0);
    chk({nm, "_done_err_same"}, n_coinc, (cap && nlines != V) ? 1 : 0);
    chk({nm, "_queue_empty"}, qd.size(), 0);
    chk({nm, "_busy_after"}, {31'd0, O_BUSY}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RST_N = 1'b0;
    I_EN    = 1'b1;
    I_PCLK  = 1'b0;
    I_VSYNC = 1'b0;
    I_HREF  = 1'b0;
    I_DATA  = 8'h00;
    repeat (3) @(negedge I_CLK);
    chk("rst_valid", {31'd0, O_PIX_VALID}, 32'd0);
    chk("rst_data", {16'd0, O_PIX_DATA}, 32'd0);
    chk("rst_addr", {28'd0, O_PIX_ADDR}, 32'd0);
    chk("rst_flags", {28'd0, O_FRAME_DONE, O_LINE_ERR, O_FRAME_ERR, O_BUSY}, 32'd0);
    I_RST_N = 1'b1;
    @(negedge I_CLK);

    run_frame("partial", 3, -1, 1'b1, 1'b1, -1);
    run_frame("basic",   3, -1, 1'b1, 1'b1, -1);
    run_frame("long",    3,  1, 1'b1, 1'b1, -1);
    run_frame("short",   2, -1, 1'b1, 1'b1, -1);
    run_frame("en_off",  3, -1, 1'b0, 1'b1, -1);
    run_frame("en_on",   3, -1, 1'b1, 1'b0, -1);
    run_frame("reset",   3, -1, 1'b1, 1'b1,  5);
    run_frame("after",   3, -1, 1'b1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
